shooter_ball: RTL and testbench
===============================

// Module: shooter_ball
// PURPOSE
//  Producer end of the path insertion interface. Owns the player's launcher and the one in-flight ball.
//  Drives Shooted_pos_X/Y and Color_out into path, and consumes path's "inserted" indication.
//  Exposes the next-ball colour to the renderer.
//  The ball flies straight down from the launcher. It is consumed on "inserted" or retired when it leaves the play area.
// PARAMETERS
//  SHOOTER_X0   304  launcher reset/start X (ball top-left)
//  SHOOTER_Y    32   parked ball Y; must be >32 px from path row Y=400
//  X_MIN        0    leftmost launcher X
//  X_MAX        608  rightmost launcher X
//  MOVE_STEP    4    launcher px per frame while key held
//  BALL_SPEED   8    ball px per frame while flying
//  Y_LIMIT      448  flying ball retired (miss) when Y would exceed this
// PORTS
//  Clk             in   1   50 MHz system clock
//  Reset           in   1   synchronous reset, ACTIVE-LOW
//  frame_clk       in   1   one-Clk pulse per video frame
//  Game_State      in   2   2'd1 = playing; any other value = not playing
//  key_left        in   1   level; move launcher left
//  key_right       in   1   level; move launcher right
//  key_fire        in   1   level; rising edge fires
//  random_color    in   2   free-running random source
//  inserted        in   1   high for every cycle path spends inserting this ball
//  Shooted_pos_X   out  10  ball X (parked = Shooter_X)
//  Shooted_pos_Y   out  10  ball Y (parked = SHOOTER_Y)
//  Color_out       out  4   current ball colour, 1..4; 0 = none
//  Next_color      out  4   queued colour, 1..4; 0 = none
//  Shooter_X       out  10  launcher X
//  flying          out  1   ball in flight
//  shot_count      out  16  balls fired since game start
// BEHAVIOUR
//  Reset (Reset==0 at posedge) values:
//   - state IDLE; Shooter_X = Shooted_pos_X = SHOOTER_X0; Shooted_pos_Y = SHOOTER_Y.
//   - Color_out = Next_color = 0; flying = 0; shot_count = 0; fire edge register = 0.
//  Fire edge: fire_q <= key_fire every cycle. fire_edge = key_fire & ~fire_q.
//  Colours are always {2'b0, random_color} + 1, i.e. the range 1..4.
//  States:
//   - IDLE: ball parked, colours 0. Game_State==1 -> LOAD_CUR; shot_count cleared on this transition.
//   - LOAD_CUR (1 cycle): Color_out <= colour -> LOAD_NEXT.
//   - LOAD_NEXT (1 cycle): Next_color <= colour -> READY.
//   - READY: on fire_edge -> FLY. Latch Shooted_pos_X = Shooter_X, Shooted_pos_Y = SHOOTER_Y, flying <= 1, shot_count += 1 (wraps at 16 bits).
//   - FLY, on each frame_clk:
//     - if Shooted_pos_Y + BALL_SPEED > Y_LIMIT -> RELOAD (miss);
//     - else Y += BALL_SPEED.
//     - X is fixed during flight.
//   - FLY, inserted==1: -> RELOAD immediately; takes priority over same-cycle frame_clk or miss.
//   - RELOAD: ball parked (X = Shooter_X, Y = SHOOTER_Y), flying = 0.
//     - Color_out is HELD while inserted==1, because path samples it during its multi-cycle insert.
//     - First cycle with inserted==0: Color_out <= Next_color, Next_color <= new colour -> READY.
//  Launcher: on frame_clk in any playing state, X moves by MOVE_STEP.
//   - Right when key_right & ~key_left; left when key_left & ~key_right; both/neither = no move.
//   - Clamped to [X_MIN, X_MAX]; no wrap (compare before add/sub in 10-bit).
//  Parked ball tracks Shooter_X combinationally from the register (same-cycle).
//  fire_edge in FLY/RELOAD/LOAD is ignored; it is not queued.
//  inserted outside FLY/RELOAD is ignored.
//  Game_State!=1 in any state -> IDLE next cycle.
//   - Colours cleared, flying=0, ball parked; Shooter_X and shot_count retained.
//  Reset mid-flight: all outputs to reset values next edge; no pending insert remembered.
//  No combinational path from inputs to outputs; all outputs registered.
// TESTING
//  1. Reset low 2 cycles, then Game_State=1, random_color=2 then 0 -> after 3 cycles Color_out=3, Next_color=1, state READY, Y=32.
//  2. key_fire rise at X=304, 10 frames, no inserted -> flying=1, shot_count=1, Y=112 after 10 frames.
//     Continue -> retired when Y+8>448 (Y=448 final frame, then parks); Color_out=1, Next_color=new.
//  3. In FLY, inserted held 5 cycles -> Color_out stable all 5 cycles, flying=0 after first; colour swap on 6th cycle.
//  4. key_right held 100 frames from X=600 -> Shooter_X=608 and stays; key_left from 2 -> stops at 0, never 1020.
//  5. inserted and frame_clk same cycle in FLY -> RELOAD, Y parked at 32 (no +8). Fire held high continuously -> only one shot.
//  6. Game_State 1->0 mid-flight -> next cycle flying=0, Color_out=0, Y=32; Game_State->1 reloads colours, shot_count=0.

Source files
------------

// File: rtl/shooter_ball.sv
// Launcher and single in-flight ball: the producer end of the path insertion interface.
// The ball drops straight down from the launcher until path reports it inserted or it leaves the play area.
module shooter_ball #(
    parameter logic [9:0] SHOOTER_X0 = 10'd304,
    parameter logic [9:0] SHOOTER_Y  = 10'd32,
    parameter logic [9:0] X_MIN      = 10'd0,
    parameter logic [9:0] X_MAX      = 10'd608,
    parameter logic [9:0] MOVE_STEP  = 10'd4,
    parameter logic [9:0] BALL_SPEED = 10'd8,
    parameter logic [9:0] Y_LIMIT    = 10'd448
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [1:0]  Game_State,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_fire,
    input  logic [1:0]  random_color,
    input  logic        inserted,
    output logic [9:0]  Shooted_pos_X,
    output logic [9:0]  Shooted_pos_Y,
    output logic [3:0]  Color_out,
    output logic [3:0]  Next_color,
    output logic [9:0]  Shooter_X,
    output logic        flying,
    output logic [15:0] shot_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CUR,
        LOAD_NEXT,
        READY,
        FLY,
        RELOAD
    } state_t;

    state_t      state, state_next;

    logic [9:0]  shooter_x, shooter_x_d;
    logic [9:0]  ball_x, ball_x_d;
    logic [9:0]  ball_y, ball_y_d;
    logic [3:0]  color_cur, color_cur_d;
    logic [3:0]  color_nxt, color_nxt_d;
    logic        fly, fly_d;
    logic [15:0] shots, shots_d;
    logic        fire_q;

    logic        playing;
    logic        fire_edge;
    logic [3:0]  new_color;
    logic [10:0] ball_y_step;
    logic        miss;

    assign playing     = (Game_State == 2'd1);
    assign fire_edge   = key_fire & ~fire_q;
    assign new_color   = {2'b00, random_color} + 4'd1;
    assign ball_y_step = {1'b0, ball_y} + {1'b0, BALL_SPEED};
    assign miss        = (ball_y_step > {1'b0, Y_LIMIT});

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            shooter_x <= SHOOTER_X0;
            ball_x    <= SHOOTER_X0;
            ball_y    <= SHOOTER_Y;
            color_cur <= '0;
            color_nxt <= '0;
            fly       <= 1'b0;
            shots     <= '0;
            fire_q    <= 1'b0;
        end else begin
            state     <= state_next;
            shooter_x <= shooter_x_d;
            ball_x    <= ball_x_d;
            ball_y    <= ball_y_d;
            color_cur <= color_cur_d;
            color_nxt <= color_nxt_d;
            fly       <= fly_d;
            shots     <= shots_d;
            fire_q    <= key_fire;
        end
    end

    always_comb begin
        state_next = state;
        if (!playing) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:      state_next = LOAD_CUR;
                LOAD_CUR:  state_next = LOAD_NEXT;
                LOAD_NEXT: state_next = READY;
                READY:     if (fire_edge) state_next = FLY;
                FLY:       if (inserted || (frame_clk && miss)) state_next = RELOAD;
                RELOAD:    if (!inserted) state_next = READY;
                default:   state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        shooter_x_d = shooter_x;
        ball_x_d    = ball_x;
        ball_y_d    = ball_y;
        color_cur_d = color_cur;
        color_nxt_d = color_nxt;
        fly_d       = fly;
        shots_d     = shots;

        if (!playing) begin
            // Stopping keeps launcher position and score; only the ball and colours are cleared.
            color_cur_d = '0;
            color_nxt_d = '0;
            fly_d       = 1'b0;
            ball_y_d    = SHOOTER_Y;
        end else begin
            case (state)
                IDLE: begin
                    shots_d = '0;
                end
                LOAD_CUR: begin
                    color_cur_d = new_color;
                end
                LOAD_NEXT: begin
                    color_nxt_d = new_color;
                end
                READY: begin
                    if (fire_edge) begin
                        ball_x_d = shooter_x;
                        ball_y_d = SHOOTER_Y;
                        fly_d    = 1'b1;
                        shots_d  = shots + 16'd1;
                    end
                end
                FLY: begin
                    // Insertion wins over a same-cycle frame step or miss.
                    if (inserted || (frame_clk && miss)) begin
                        fly_d    = 1'b0;
                        ball_y_d = SHOOTER_Y;
                    end else if (frame_clk) begin
                        ball_y_d = ball_y_step[9:0];
                    end
                end
                RELOAD: begin
                    fly_d    = 1'b0;
                    ball_y_d = SHOOTER_Y;
                    if (!inserted) begin
                        color_cur_d = color_nxt;
                        color_nxt_d = new_color;
                    end
                end
                default: begin
                    fly_d = 1'b0;
                end
            endcase

            if (frame_clk && (state != IDLE)) begin
                if (key_right && !key_left) begin
                    if (shooter_x >= X_MAX - MOVE_STEP)
                        shooter_x_d = X_MAX;
                    else
                        shooter_x_d = shooter_x + MOVE_STEP;
                end else if (key_left && !key_right) begin
                    if (shooter_x <= X_MIN + MOVE_STEP)
                        shooter_x_d = X_MIN;
                    else
                        shooter_x_d = shooter_x - MOVE_STEP;
                end
            end
        end
    end

    // A parked ball follows the launcher register directly, so it moves in the same cycle.
    assign Shooted_pos_X = fly ? ball_x : shooter_x;
    assign Shooted_pos_Y = ball_y;
    assign Color_out     = color_cur;
    assign Next_color    = color_nxt;
    assign Shooter_X     = shooter_x;
    assign flying        = fly;
    assign shot_count    = shots;

endmodule

// File: tb/tb_shooter_ball.sv
// Scoreboard bench for shooter_ball: expectations are queued as stimulus is applied and compared on output.
module tb_shooter_ball;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        frame_clk = 1'b0;
    logic [1:0]  Game_State = 2'd0;
    logic        key_left = 1'b0;
    logic        key_right = 1'b0;
    logic        key_fire = 1'b0;
    logic [1:0]  random_color = 2'd0;
    logic        inserted = 1'b0;
    logic        key_left2 = 1'b0;
    logic        key_right2 = 1'b0;

    logic [9:0]  pos_x, pos_y, shooter_x;
    logic [3:0]  color_out, next_color;
    logic        flying;
    logic [15:0] shot_count;

    logic [9:0]  u2_pos_x, u2_pos_y, u2_shooter_x;
    logic [3:0]  u2_color_out, u2_next_color;
    logic        u2_flying;
    logic [15:0] u2_shot_count;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e;

    shooter_ball dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
        .key_left(key_left), .key_right(key_right), .key_fire(key_fire),
        .random_color(random_color), .inserted(inserted),
        .Shooted_pos_X(pos_x), .Shooted_pos_Y(pos_y), .Color_out(color_out),
        .Next_color(next_color), .Shooter_X(shooter_x), .flying(flying),
        .shot_count(shot_count)
    );

    shooter_ball #(.SHOOTER_X0(10'd2)) dut2 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Game_State(Game_State),
        .key_left(key_left2), .key_right(key_right2), .key_fire(key_fire),
        .random_color(random_color), .inserted(inserted),
        .Shooted_pos_X(u2_pos_x), .Shooted_pos_Y(u2_pos_y), .Color_out(u2_color_out),
        .Next_color(u2_next_color), .Shooter_X(u2_shooter_x), .flying(u2_flying),
        .shot_count(u2_shot_count)
    );

    always #10 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Game_State = 2'd0;
        tick();
        tick();
        exp_q.push_back(16'd304);
        exp_q.push_back(16'd304);
        exp_q.push_back(16'd32);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd0);
        e = exp_q.pop_front(); checks++;
        if (shooter_x !== e[9:0]) begin failures++; $display("FAIL reset_shooter_x got=%0d exp=%0d", shooter_x, e); end
        e = exp_q.pop_front(); checks++;
        if (pos_x !== e[9:0]) begin failures++; $display("FAIL reset_pos_x got=%0d exp=%0d", pos_x, e); end
        e = exp_q.pop_front(); checks++;
        if (pos_y !== e[9:0]) begin failures++; $display("FAIL reset_pos_y got=%0d exp=%0d", pos_y, e); end
        e = exp_q.pop_front(); checks++;
        if (color_out !== e[3:0]) begin failures++; $display("FAIL reset_color got=%0d exp=%0d", color_out, e); end
        e = exp_q.pop_front(); checks++;
        if (next_color !== e[3:0]) begin failures++; $display("FAIL reset_next got=%0d exp=%0d", next_color, e); end
        e = exp_q.pop_front(); checks++;
        if ({15'd0, flying} !== e) begin failures++; $display("FAIL reset_flying got=%0d exp=%0d", flying, e); end
        e = exp_q.pop_front(); checks++;
        if (shot_count !== e) begin failures++; $display("FAIL reset_shots got=%0d exp=%0d", shot_count, e); end
    endtask

    task automatic test_load();
        Reset = 1'b1;
        Game_State = 2'd1;
        random_color = 2'd2;
        tick();
        tick();
        random_color = 2'd0;
        tick();
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd32);
        e = exp_q.pop_front(); checks++;
        if (color_out !== e[3:0]) begin failures++; $display("FAIL load_color got=%0d exp=%0d", color_out, e); end
        e = exp_q.pop_front(); checks++;
        if (next_color !== e[3:0]) begin failures++; $display("FAIL load_next got=%0d exp=%0d", next_color, e); end
        e = exp_q.pop_front(); checks++;
        if (pos_y !== e[9:0]) begin failures++; $display("FAIL load_pos_y got=%0d exp=%0d", pos_y, e); end
    endtask

    task automatic test_fly_miss();
        int exp_y;
        random_color = 2'd3;
        key_fire = 1'b1;
        tick();
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd304);
        e = exp_q.pop_front(); checks++;
        if ({15'd0, flying} !== e) begin failures++; $display("FAIL fire_flying got=%0d exp=%0d", flying, e); end
        e = exp_q.pop_front(); checks++;
        if (shot_count !== e) begin failures++; $display("FAIL fire_shots got=%0d exp=%0d", shot_count, e); end
        e = exp_q.pop_front(); checks++;
        if (pos_x !== e[9:0]) begin failures++; $display("FAIL fire_pos_x got=%0d exp=%0d", pos_x, e); end

        exp_y = 32;
        for (int i = 0; i < 10; i++) begin
            frame();
            exp_y = exp_y + 8;
            exp_q.push_back(16'(exp_y));
            e = exp_q.pop_front(); checks++;
            if (pos_y !== e[9:0]) begin failures++; $display("FAIL fly_pos_y frame=%0d got=%0d exp=%0d", i, pos_y, e); end
        end

        key_fire = 1'b0;
        tick();
        key_fire = 1'b1;
        tick();
        exp_q.push_back(16'd1);
        e = exp_q.pop_front(); checks++;
        if (shot_count !== e) begin failures++; $display("FAIL refire_in_flight got=%0d exp=%0d", shot_count, e); end

        for (int i = 0; i < 42; i++) begin
            frame();
            exp_y = exp_y + 8;
        end
        exp_q.push_back(16'(exp_y));
        exp_q.push_back(16'd1);
        e = exp_q.pop_front(); checks++;
        if (pos_y !== e[9:0]) begin failures++; $display("FAIL fly_last_y got=%0d exp=%0d", pos_y, e); end
        e = exp_q.pop_front(); checks++;
        if ({15'd0, flying} !== e) begin failures++; $display("FAIL fly_last_flying got=%0d exp=%0d", flying, e); end

        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd32);
        exp_q.push_back(16'd3);
        e = exp_q.pop_front(); checks++;
        if ({15'd0, flying} !== e) begin failures++; $display("FAIL miss_flying got=%0d exp=%0d", flying, e); end
        e = exp_q.pop_front(); checks++;
        if (pos_y !== e[9:0]) begin failures++; $display("FAIL miss_pos_y got=%0d exp=%0d", pos_y, e); end
        e = exp_q.pop_front(); checks++;
        if (color_out !== e[3:0]) begin failures++; $display("FAIL miss_color_held got=%0d exp=%0d", color_out, e); end

        tick();
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd4);
        e = exp_q.pop_front(); checks++;
        if (color_out !== e[3:0]) begin failures++; $display("FAIL miss_swap_color got=%0d exp=%0d", color_out, e); end
        e = exp_q.pop_front(); checks++;
        if (next_color !== e[3:0]) begin failures++; $display("FAIL miss_swap_next got=%0d exp=%0d", next_color, e); end

        tick();
        tick();
        tick();
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd0);
        e = exp_q.pop_front(); checks++;
        if (shot_count !== e) begin failures++; $display("FAIL held_fire_shots got=%0d exp=%0d", shot_count, e); end
        e = exp_q.pop_front(); checks++;
        if ({15'd0, flying} !== e) begin failures++; $display("FAIL held_fire_flying got=%0d exp=%0d", flying, e); end
    endtask

    task automatic test_insert();
        key_fire = 1'b0;
        tick();
        key_fire = 1'b1;
        tick();
        random_color = 2'd1;
        exp_q.push_back(16'd2);
        e = exp_q.pop_front(); checks++;
        if (shot_count !== e) begin failures++; $display("FAIL ins_fire_shots got=%0d exp=%0d", shot_count, e); end
        frame();
        exp_q.push_back(16'd40);
        e = exp_q.pop_front(); checks++;
        if (pos_y !== e[9:0]) begin failures++; $display("FAIL ins_pre_y got=%0d exp=%0d", pos_y, e); end

        inserted = 1'b1;
        frame_clk = 1'b1;
        tick();
        frame_clk = 1'b0;
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd32);
        e = exp_q.pop_front(); checks++;
        if ({15'd0, flying} !== e) begin failures++; $display("FAIL ins_flying got=%0d exp=%0d", flying, e); end
        e = exp_q.pop_front(); checks++;
        if (pos_y !== e[9:0]) begin failures++; $display("FAIL ins_frame_prio_y got=%0d exp=%0d", pos_y, e); end

        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            exp_q.push_back(16'd1);
            exp_q.push_back(16'd4);
            e = exp_q.pop_front(); checks++;
            if (color_out !== e[3:0]) begin failures++; $display("FAIL ins_hold_color cyc=%0d got=%0d exp=%0d", i, color_out, e); end
            e = exp_q.pop_front(); checks++;
            if (next_color !== e[3:0]) begin failures++; $display("FAIL ins_hold_next cyc=%0d got=%0d exp=%0d", i, next_color, e); end
        end

        inserted = 1'b0;
        tick();
        exp_q.push_back(16'd4);
        exp_q.push_back(16'd2);
        e = exp_q.pop_front(); checks++;
        if (color_out !== e[3:0]) begin failures++; $display("FAIL ins_swap_color got=%0d exp=%0d", color_out, e); end
        e = exp_q.pop_front(); checks++;
        if (next_color !== e[3:0]) begin failures++; $display("FAIL ins_swap_next got=%0d exp=%0d", next_color, e); end
    endtask

    task automatic test_launcher();
        int exp_x;
        exp_x = 304;
        key_right = 1'b1;
        for (int i = 0; i < 174; i++) begin
            frame();
            exp_x = (exp_x + 4 > 608) ? 608 : exp_x + 4;
            exp_q.push_back(16'(exp_x));
            exp_q.push_back(16'(exp_x));
            e = exp_q.pop_front(); checks++;
            if (shooter_x !== e[9:0]) begin failures++; $display("FAIL right_x frame=%0d got=%0d exp=%0d", i, shooter_x, e); end
            e = exp_q.pop_front(); checks++;
            if (pos_x !== e[9:0]) begin failures++; $display("FAIL right_parked_x frame=%0d got=%0d exp=%0d", i, pos_x, e); end
        end
        key_right = 1'b0;
        key_left = 1'b1;
        for (int i = 0; i < 160; i++) begin
            frame();
            exp_x = (exp_x < 4) ? 0 : exp_x - 4;
            exp_q.push_back(16'(exp_x));
            e = exp_q.pop_front(); checks++;
            if (shooter_x !== e[9:0]) begin failures++; $display("FAIL left_x frame=%0d got=%0d exp=%0d", i, shooter_x, e); end
        end
        key_right = 1'b1;
        frame();
        key_right = 1'b0;
        key_left = 1'b0;
        exp_q.push_back(16'd0);
        e = exp_q.pop_front(); checks++;
        if (shooter_x !== e[9:0]) begin failures++; $display("FAIL both_keys_x got=%0d exp=%0d", shooter_x, e); end

        exp_q.push_back(16'd2);
        e = exp_q.pop_front(); checks++;
        if (u2_shooter_x !== e[9:0]) begin failures++; $display("FAIL odd_start_x got=%0d exp=%0d", u2_shooter_x, e); end
        key_left2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            frame();
            exp_q.push_back(16'd0);
            e = exp_q.pop_front(); checks++;
            if (u2_shooter_x !== e[9:0]) begin failures++; $display("FAIL odd_left_x frame=%0d got=%0d exp=%0d", i, u2_shooter_x, e); end
        end
        key_left2 = 1'b0;
    endtask

    task automatic test_stop();
        key_fire = 1'b0;
        tick();
        key_fire = 1'b1;
        tick();
        frame();
        Game_State = 2'd0;
        tick();
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd32);
        exp_q.push_back(16'd3);
        exp_q.push_back(16'd0);
        e = exp_q.pop_front(); checks++;
        if ({15'd0, flying} !== e) begin failures++; $display("FAIL stop_flying got=%0d exp=%0d", flying, e); end
        e = exp_q.pop_front(); checks++;
        if (color_out !== e[3:0]) begin failures++; $display("FAIL stop_color got=%0d exp=%0d", color_out, e); end
        e = exp_q.pop_front(); checks++;
        if (pos_y !== e[9:0]) begin failures++; $display("FAIL stop_pos_y got=%0d exp=%0d", pos_y, e); end
        e = exp_q.pop_front(); checks++;
        if (shot_count !== e) begin failures++; $display("FAIL stop_shots_kept got=%0d exp=%0d", shot_count, e); end
        e = exp_q.pop_front(); checks++;
        if (pos_x !== e[9:0]) begin failures++; $display("FAIL stop_parked_x got=%0d exp=%0d", pos_x, e); end

        Game_State = 2'd1;
        random_color = 2'd0;
        tick();
        exp_q.push_back(16'd0);
        e = exp_q.pop_front(); checks++;
        if (shot_count !== e) begin failures++; $display("FAIL restart_shots got=%0d exp=%0d", shot_count, e); end
        tick();
        tick();
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd1);
        e = exp_q.pop_front(); checks++;
        if (color_out !== e[3:0]) begin failures++; $display("FAIL restart_color got=%0d exp=%0d", color_out, e); end
        e = exp_q.pop_front(); checks++;
        if (next_color !== e[3:0]) begin failures++; $display("FAIL restart_next got=%0d exp=%0d", next_color, e); end
    endtask

    task automatic test_reset_mid();
        key_right = 1'b1;
        frame();
        key_right = 1'b0;
        key_fire = 1'b0;
        tick();
        key_fire = 1'b1;
        tick();
        frame();
        inserted = 1'b1;
        Reset = 1'b0;
        tick();
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd32);
        exp_q.push_back(16'd304);
        exp_q.push_back(16'd0);
        exp_q.push_back(16'd0);
        e = exp_q.pop_front(); checks++;
        if ({15'd0, flying} !== e) begin failures++; $display("FAIL rmid_flying got=%0d exp=%0d", flying, e); end
        e = exp_q.pop_front(); checks++;
        if (pos_y !== e[9:0]) begin failures++; $display("FAIL rmid_pos_y got=%0d exp=%0d", pos_y, e); end
        e = exp_q.pop_front(); checks++;
        if (pos_x !== e[9:0]) begin failures++; $display("FAIL rmid_pos_x got=%0d exp=%0d", pos_x, e); end
        e = exp_q.pop_front(); checks++;
        if (color_out !== e[3:0]) begin failures++; $display("FAIL rmid_color got=%0d exp=%0d", color_out, e); end
        e = exp_q.pop_front(); checks++;
        if (shot_count !== e) begin failures++; $display("FAIL rmid_shots got=%0d exp=%0d", shot_count, e); end

        Reset = 1'b1;
        inserted = 1'b0;
        key_fire = 1'b0;
        random_color = 2'd3;
        tick();
        tick();
        tick();
        exp_q.push_back(16'd4);
        exp_q.push_back(16'd4);
        e = exp_q.pop_front(); checks++;
        if (color_out !== e[3:0]) begin failures++; $display("FAIL rmid_reload_color got=%0d exp=%0d", color_out, e); end
        e = exp_q.pop_front(); checks++;
        if (next_color !== e[3:0]) begin failures++; $display("FAIL rmid_reload_next got=%0d exp=%0d", next_color, e); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_fly_miss();
        test_insert();
        test_launcher();
        test_stop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
